// File: rtl/mul_div_unit_if.sv
// mul_div_unit_if: operand request and HI/LO result bundle between the execute stage and mul_div_unit.
interface mul_div_unit_if #(
   parameter int BitWidth = 32
);
   logic                start;
   logic [1:0]          op;
   logic [BitWidth-1:0] a;
   logic [BitWidth-1:0] b;
   logic                flush;
   logic                busy;
   logic                done;
   logic                hiWrite;
   logic                loWrite;
   logic [BitWidth-1:0] hi;
   logic [BitWidth-1:0] lo;
   modport master (output start, op, a, b, flush, input busy, done, hiWrite, loWrite, hi, lo);
   modport slave (input start, op, a, b, flush, output busy, done, hiWrite, loWrite, hi, lo);
endinterface

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative MULT/MULTU/DIV/DIVU (shift-add / restoring division) feeding the HI/LO registers.
module mul_div_unit #(
   parameter int BitWidth = 32
) (
   input  logic          clock,
   input  logic          reset,
   mul_div_unit_if.slave bus
);
   localparam int W  = BitWidth;
   localparam int CW = $clog2(W);
   typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [1:0]       op_q, op_d;
   logic [2*W-1:0]   acc_q, acc_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     hi_q, hi_d;
   logic [W-1:0]     lo_q, lo_d;
   logic             qneg_q, qneg_d;
   logic             rneg_q, rneg_d;
   logic             dz_q, dz_d;
   logic             a_neg, b_neg, ge;
   logic [W-1:0]     a_abs, b_abs, quo, rmd;
   logic [W:0]       sum, rem, diff;
   logic [2*W-1:0]   mul_step, div_step, prod;
   always_comb begin
      a_neg    = ~bus.op[0] & bus.a[W-1];
      b_neg    = ~bus.op[0] & bus.b[W-1];
      a_abs    = a_neg ? -bus.a : bus.a;
      b_abs    = b_neg ? -bus.b : bus.b;
      sum      = {1'b0, acc_q[2*W-1:W]} + {1'b0, acc_q[0] ? b_q : {W{1'b0}}};
      mul_step = {sum, acc_q[W-1:1]};
      // partial remainder shifted left by one, dividend bits enter MSB first
      rem      = {acc_q[2*W-1:W], acc_q[W-1]};
      diff     = rem - {1'b0, b_q};
      ge       = ~diff[W];
      div_step = {ge ? diff[W-1:0] : rem[W-1:0], acc_q[W-2:0], ge};
      prod     = qneg_q ? -acc_q : acc_q;
      quo      = qneg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
      rmd      = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      acc_d    = acc_q;
      b_d      = b_q;
      a_d      = a_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      if (bus.flush) begin
         state_d = IDLE;
      end else if (state_q == IDLE || state_q == DONE) begin
         state_d = bus.start ? RUN : IDLE;
         if (bus.start) begin
            op_d   = bus.op;
            acc_d  = {{W{1'b0}}, a_abs};
            b_d    = b_abs;
            a_d    = bus.a;
            qneg_d = a_neg ^ b_neg;
            rneg_d = a_neg;
            dz_d   = bus.b == '0;
            cnt_d  = CW'(W - 1);
         end
      end else if (state_q == RUN) begin
         acc_d   = op_q[1] ? div_step : mul_step;
         cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
         state_d = cnt_q == '0 ? FIX : RUN;
      end else begin
         state_d      = DONE;
         {hi_d, lo_d} = !op_q[1] ? prod : dz_q ? {a_q, {W{1'b1}}} : {rmd, quo};
      end
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         b_q     <= '0;
         a_q     <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         b_q     <= b_d;
         a_q     <= a_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
         qneg_q  <= qneg_d;
         rneg_q  <= rneg_d;
         dz_q    <= dz_d;
      end
   end
   assign bus.busy    = state_q == RUN || state_q == FIX;
   assign bus.done    = state_q == DONE;
   assign bus.hiWrite = state_q == DONE;
   assign bus.loWrite = state_q == DONE;
   assign bus.hi      = hi_q;
   assign bus.lo      = lo_q;
endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: table vectors, random ops against an arithmetic model, and start/flush/reset sequences.
module tb_mul_div_unit;
   localparam int W = 32;
   logic clock = 1'b0;
   logic reset = 1'b1;
   mul_div_unit_if #(.BitWidth(W)) bus ();
   mul_div_unit #(.BitWidth(W)) dut (.clock(clock), .reset(reset), .bus(bus));
   always #5 clock = ~clock;
   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;
   vec_t        vecs[10];
   int          checks = 0;
   int          failures = 0;
   int          lat, bsy, ndone, bad, dcyc[2];
   logic        was_busy;
   logic [63:0] r, res[2];
   logic [1:0]  rop;
   logic [31:0] ra, rb;
   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      longint          sa = longint'($signed(a));
      longint          sb = longint'($signed(b));
      longint unsigned ua = 64'(a);
      longint unsigned ub = 64'(b);
      case (op)
         2'd0:    return 64'(sa * sb);
         2'd1:    return ua * ub;
         2'd2:    return b == 0 ? {a, 32'hFFFFFFFF} : {32'(sa % sb), 32'(sa / sb)};
         default: return b == 0 ? {a, 32'hFFFFFFFF} : {32'(ua % ub), 32'(ua / ub)};
      endcase
   endfunction
   // entered just after a rising edge; leaves just after the edge ending the done cycle
   task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [63:0] res_o, output int lat_o, output int bsy_o);
      bus.op = o;
      bus.a = x;
      bus.b = y;
      bus.start = 1'b1;
      @(posedge clock);
      #1 bus.start = 1'b0;
      lat_o = 0;
      bsy_o = 0;
      res_o = '0;
      while (lat_o < 100) begin
         @(negedge clock);
         lat_o++;
         if (bus.done) break;
         if (bus.busy) bsy_o++;
      end
      if (bus.done) begin
         res_o = {bus.hi, bus.lo};
         chk("strobes", {61'd0, bus.hiWrite, bus.loWrite, bus.busy}, 64'd6);
      end
      @(posedge clock);
      #1;
   endtask
   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
   initial begin
      vecs[0] = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[1] = '{2'd0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2] = '{2'd2, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{2'd3, 32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF};
      vecs[4] = '{2'd2, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5] = '{2'd3, 32'd100,      32'd7,        32'd2,        32'd14};
      vecs[6] = '{2'd2, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF};
      vecs[7] = '{2'd0, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[8] = '{2'd2, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9] = '{2'd1, 32'h00000000, 32'h12345678, 32'h00000000, 32'h00000000};
      bus.start = 1'b0;
      bus.op = 2'd0;
      bus.a = '0;
      bus.b = '0;
      bus.flush = 1'b0;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_state", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);
      chk("reset_strobes", {62'd0, bus.hiWrite, bus.loWrite}, 64'd0);
      reset = 1'b0;
      @(posedge clock);
      #1;
      for (int i = 0; i < 10; i++) begin
         run_op(vecs[i].op, vecs[i].a, vecs[i].b, r, lat, bsy);
         chk($sformatf("vec%0d_result", i), r, {vecs[i].hi, vecs[i].lo});
         chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
         if (i == 0) chk("vec0_busy_cycles", 64'(bsy), 64'd33);
      end
      for (int i = 0; i < 200; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra = $urandom_range(0, 7) == 0 ? 32'h80000000 : $urandom;
         case ($urandom_range(0, 7))
            0:       rb = 32'd0;
            1:       rb = 32'hFFFFFFFF;
            2:       rb = 32'($urandom_range(1, 15));
            default: rb = $urandom;
         endcase
         run_op(rop, ra, rb, r, lat, bsy);
         chk($sformatf("rand%0d op%0d a=%h b=%h", i, rop, ra, rb), r, model(rop, ra, rb));
         chk($sformatf("rand%0d_latency", i), 64'(lat), 64'd34);
      end
      // DIVU 100/7 at cycle 0, ignored MULTU at cycle 5, accepted MULTU in the done cycle
      ndone = 0;
      for (int c = 0; c <= 72; c++) begin
         bus.start = c == 0 || c == 5 || c == 34;
         bus.op = c == 0 ? 2'd3 : 2'd1;
         bus.a = c == 0 ? 32'd100 : 32'd2;
         bus.b = c == 0 ? 32'd7 : 32'd3;
         @(negedge clock);
         if (bus.done) begin
            if (ndone < 2) begin
               res[ndone] = {bus.hi, bus.lo};
               dcyc[ndone] = c;
            end
            ndone++;
         end
         @(posedge clock);
         #1;
      end
      bus.start = 1'b0;
      chk("b2b_done_count", 64'(ndone), 64'd2);
      chk("b2b_first_cycle", 64'(dcyc[0]), 64'd34);
      chk("b2b_first_result", res[0], {32'd2, 32'd14});
      chk("b2b_second_cycle", 64'(dcyc[1]), 64'd68);
      chk("b2b_second_result", res[1], {32'd0, 32'd6});
      // flush mid-RUN
      ndone = 0;
      bad = 0;
      was_busy = 1'b0;
      for (int c = 0; c <= 45; c++) begin
         bus.start = c == 0;
         bus.op = 2'd1;
         bus.a = 32'd9;
         bus.b = 32'd9;
         bus.flush = c == 10;
         @(negedge clock);
         if (c == 10) was_busy = bus.busy;
         if (bus.done) ndone++;
         if (c >= 11 && bus.busy) bad++;
         @(posedge clock);
         #1;
      end
      bus.flush = 1'b0;
      chk("flush_was_busy", 64'(was_busy), 64'd1);
      chk("flush_busy_after", 64'(bad), 64'd0);
      chk("flush_no_done", 64'(ndone), 64'd0);
      chk("flush_hold_hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});
      // flush and start together: nothing starts
      ndone = 0;
      bad = 0;
      for (int c = 0; c <= 40; c++) begin
         bus.start = c == 0;
         bus.flush = c == 0;
         @(negedge clock);
         if (bus.done) ndone++;
         if (bus.busy) bad++;
         @(posedge clock);
         #1;
      end
      bus.start = 1'b0;
      bus.flush = 1'b0;
      chk("flush_start_busy", 64'(bad), 64'd0);
      chk("flush_start_no_done", 64'(ndone), 64'd0);
      chk("flush_start_hilo", {bus.hi, bus.lo}, {32'd0, 32'd6});
      // asynchronous reset mid-RUN
      was_busy = 1'b0;
      for (int c = 0; c < 15; c++) begin
         bus.start = c == 0;
         bus.op = 2'd1;
         bus.a = 32'd9;
         bus.b = 32'd9;
         @(negedge clock);
         if (c == 14) was_busy = bus.busy;
         @(posedge clock);
         #1;
      end
      bus.start = 1'b0;
      #2 reset = 1'b1;
      #1;
      chk("areset_was_busy", 64'(was_busy), 64'd1);
      chk("areset_state", {30'd0, bus.busy, bus.done, bus.hi, bus.lo}, 64'd0);
      #3 reset = 1'b0;
      @(posedge clock);
      #1;
      run_op(2'd1, 32'd3, 32'd4, r, lat, bsy);
      chk("post_reset_result", r, {32'd0, 32'd12});
      chk("post_reset_latency", 64'(lat), 64'd34);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
